adapter: RTL and testbench
==========================

Name: adapter

Overview:
- Image-transform adapter. It buffers one full frame of 24-bit pixels in on-chip SRAM and then streams the frame back out, rotated or mirrored according to op_mode.
- The frame is loaded in store mode (op_mode=000), one pixel per clock in raster order.
- In a transform mode it emits one transformed pixel per clock in output raster order.
- It sits between a pixel source and a pixel sink in the video/image path.

Parameters:
- DATA_W, 24, pixel width (RGB888).
- IMG_W, 1024, frame width in pixels; must be a power of two.
- IMG_H, 1024, frame height in pixels; must be a power of two.
- RAM_DEPTH, IMG_W*IMG_H, number of stored pixels.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_mode  in  3  000 store; 001 rot90 CW; 010 rot180; 011 rot270 (90 CCW); 100 horizontal mirror (left-right); 101 vertical mirror (top-bottom); 110/111 identity readout.
- data_in  in  DATA_W  pixel to store (store mode only).
- data_out  out  DATA_W  transformed pixel.
- jump_out  out  1  marks the last pixel of each output row.
- output_done  out  1  the frame readout is complete.

Behaviour:
- Reset: data_out=0, jump_out=0, output_done=0, write pointer=0, read counters=0, previous-mode register=000. SRAM contents are not cleared.
- Mode change: op_mode is registered every cycle. Any cycle where op_mode differs from the registered value resets the write pointer and the read counters to 0 and clears output_done. This applies to mid-operation changes too.
- Store mode (000):
  - Every non-reset cycle writes data_in to mem[wr_ptr] and increments wr_ptr.
  - wr_ptr wraps from RAM_DEPTH-1 to 0.
  - data_out, jump_out and output_done are held at 0.
- Transform modes:
  - Output dimensions: OW x OH equals IMG_H x IMG_W for 001/011, and IMG_W x IMG_H otherwise.
  - Output counters (orow, ocol) advance raster-wise, one step per cycle.
  - Source address is {srow, scol} (concatenation; no multiplier), with:
    - 001: srow=IMG_H-1-ocol, scol=orow
    - 010: srow=IMG_H-1-orow, scol=IMG_W-1-ocol
    - 011: srow=ocol, scol=IMG_W-1-orow
    - 100: srow=orow, scol=IMG_W-1-ocol
    - 101: srow=IMG_H-1-orow, scol=ocol
    - 110/111: srow=orow, scol=ocol
  - SRAM read is synchronous, so data_out is registered with 1-cycle latency. data_out in cycle k+1 is the pixel for output index k. The first valid pixel appears the cycle after the mode takes effect.
  - jump_out is high in the same cycle data_out carries a pixel with ocol=OW-1.
  - output_done goes high in the same cycle data_out carries output index RAM_DEPTH-1, and stays high (sticky) until a mode change or reset.
  - After completion, counters hold at the final index and data_out holds the last pixel. No automatic restart.
- Read and write never occur in the same cycle, so a single-port SRAM is sufficient.
- Reset mid-frame aborts the current operation. Stored pixels survive reset.

Decomposition:
- Package adapter_pkg holds:
  - mode localparams: MODE_STORE, MODE_ROT90, MODE_ROT180, MODE_ROT270, MODE_MIRH, MODE_MIRV
  - DATA_W
  - address-width function clog2
- Sub-module adapter_sram: single-port synchronous RAM, DATA_W x RAM_DEPTH, write enable, 1-cycle registered read.
- The top level contains the mode register, write pointer, output counters, address mapper and status flags.

Test Plan (IMG_W=IMG_H=4, stored pixel value = its address 0..15):
- Store 16 cycles, then mode 010 -> data_out 15,14,13,…,0; jump_out high on 12,8,4,0; output_done high with 0.
- Mode 001 -> 12,8,4,0,13,9,5,1,14,10,6,2,15,11,7,3; jump_out high on 0,1,2,3.
- Mode 011 -> 3,7,11,15,2,6,10,14,1,5,9,13,0,4,8,12.
- Mode 100 -> 3,2,1,0,7,6,5,4,… ; mode 101 -> 12,13,14,15,8,9,… ; mode 110 -> 0..15 in order.
- Assert rst mid-readout, then reissue mode 010 -> outputs restart at 15; output_done low until index 15 is emitted; SRAM contents intact.
- Switch mode 010 -> 100 mid-frame -> counters restart and the sequence restarts at 3. Storing 17 pixels wraps the write pointer, so pixel 16 overwrites address 0.

Source files
------------

// File: rtl/adapter_pkg.sv
// rtl/adapter_pkg.sv - shared constants, mode encodings and width helper for the image adapter
package adapter_pkg;

    localparam int DATA_W = 24;

    localparam logic [2:0] MODE_STORE  = 3'b000;
    localparam logic [2:0] MODE_ROT90  = 3'b001;
    localparam logic [2:0] MODE_ROT180 = 3'b010;
    localparam logic [2:0] MODE_ROT270 = 3'b011;
    localparam logic [2:0] MODE_MIRH   = 3'b100;
    localparam logic [2:0] MODE_MIRV   = 3'b101;

    // Number of address bits needed to index 'value' entries
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adapter_sram.sv
// rtl/adapter_sram.sv - single-port synchronous frame RAM with registered read
module adapter_sram
    import adapter_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per cycle; the read register holds its value while idle
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adapter.sv
// rtl/adapter.sv - frame buffer that stores a frame and streams it back rotated or mirrored
module adapter
    import adapter_pkg::*;
#(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op_mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              jump_out,
    output logic              output_done
);

    localparam int XW        = clog2(IMG_W);
    localparam int YW        = clog2(IMG_H);
    localparam int AW        = XW + YW;
    localparam int RAM_DEPTH = IMG_W * IMG_H;

    logic [2:0]        mode_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     idx_q;
    logic              done_q;
    logic              show_q;
    logic              jump_q;

    logic              mode_change;
    logic              is_rot;
    logic              row_end;
    logic              last_idx;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // The output (orow, ocol) pair is kept as one linear raster index; since
    // both dimensions are powers of two, row and column are plain bit fields
    // whose split point depends on whether the output frame is transposed.
    logic [YW-1:0]     r_ocol;
    logic [XW-1:0]     r_orow;
    logic [XW-1:0]     n_ocol;
    logic [YW-1:0]     n_orow;

    assign r_ocol = idx_q[YW-1:0];
    assign r_orow = idx_q[AW-1:YW];
    assign n_ocol = idx_q[XW-1:0];
    assign n_orow = idx_q[AW-1:XW];

    assign mode_change = (op_mode != mode_q);
    assign is_rot      = (mode_q == MODE_ROT90) || (mode_q == MODE_ROT270);
    assign row_end     = is_rot ? (&r_ocol) : (&n_ocol);
    assign last_idx    = &idx_q;

    assign wr_en = !rst && !mode_change && (mode_q == MODE_STORE);
    assign rd_en = !rst && !mode_change && (mode_q != MODE_STORE) && !done_q;

    // Source address {srow, scol}; bitwise inversion gives N-1-x for power-of-two N
    always_comb begin
        rd_addr = {n_orow, n_ocol};
        case (mode_q)
            MODE_ROT90:  rd_addr = {~r_ocol, r_orow};
            MODE_ROT270: rd_addr = {r_ocol, ~r_orow};
            MODE_ROT180: rd_addr = {~n_orow, ~n_ocol};
            MODE_MIRH:   rd_addr = {n_orow, ~n_ocol};
            MODE_MIRV:   rd_addr = {~n_orow, n_ocol};
            default:     rd_addr = {n_orow, n_ocol};
        endcase
    end

    assign ram_addr = wr_en ? wr_ptr_q : rd_addr;

    adapter_sram #(
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .we_i    (wr_en),
        .re_i    (rd_en),
        .addr_i  (ram_addr),
        .wdata_i (data_in),
        .rdata_o (ram_rdata)
    );

    // Mode tracking, write pointer, readout index and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_STORE;
            wr_ptr_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            show_q   <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            mode_q <= op_mode;
            jump_q <= 1'b0;
            if (mode_change) begin
                wr_ptr_q <= '0;
                idx_q    <= '0;
                done_q   <= 1'b0;
                show_q   <= 1'b0;
            end else if (mode_q == MODE_STORE) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                done_q   <= 1'b0;
                show_q   <= 1'b0;
            end else if (!done_q) begin
                show_q <= 1'b1;
                jump_q <= row_end;
                if (last_idx) begin
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // The RAM read register already provides the one-cycle output stage;
    // it is masked to zero until a transform read has been issued
    assign data_out    = show_q ? ram_rdata : '0;
    assign jump_out    = jump_q;
    assign output_done = done_q;

endmodule

// File: tb/tb_adapter.sv
// tb/tb_adapter.sv - self-checking bench for the image adapter on a 4x4 frame
module tb_adapter;
    import adapter_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        op_mode;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              jump_out;
    logic              output_done;

    always #5 clk = ~clk;

    adapter #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_mode     (op_mode),
        .data_in     (data_in),
        .data_out    (data_out),
        .jump_out    (jump_out),
        .output_done (output_done)
    );

    typedef struct packed {
        logic [2:0]       mode;
        logic [15:0][3:0] seq;
        logic [15:0]      jmask;
    } vec_t;

    vec_t              tbl [7];
    int                total = 0;
    int                bad   = 0;
    logic [DATA_W-1:0] model_mem [N];
    logic [DATA_W-1:0] exp_pix   [N];
    logic              exp_jump  [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_pix(input logic [2:0] m, input int k);
        int ow, orow, ocol, srow, scol;
        ow   = (m == 3'b001 || m == 3'b011) ? H : W;
        orow = k / ow;
        ocol = k % ow;
        case (m)
            3'b001:  begin srow = H - 1 - ocol; scol = orow;         end
            3'b010:  begin srow = H - 1 - orow; scol = W - 1 - ocol; end
            3'b011:  begin srow = ocol;         scol = W - 1 - orow; end
            3'b100:  begin srow = orow;         scol = W - 1 - ocol; end
            3'b101:  begin srow = H - 1 - orow; scol = ocol;         end
            default: begin srow = orow;         scol = ocol;         end
        endcase
        return model_mem[srow * W + scol];
    endfunction

    function automatic logic model_jump(input logic [2:0] m, input int k);
        int ow;
        ow = (m == 3'b001 || m == 3'b011) ? H : W;
        return (k % ow) == ow - 1;
    endfunction

    task automatic load_tbl(input int i);
        for (int k = 0; k < N; k++) begin
            exp_pix[k]  = {20'd0, tbl[i].seq[k]};
            exp_jump[k] = tbl[i].jmask[k];
        end
    endtask

    task automatic load_model(input logic [2:0] m);
        for (int k = 0; k < N; k++) begin
            exp_pix[k]  = model_pix(m, k);
            exp_jump[k] = model_jump(m, k);
        end
    endtask

    // Called in the cycle where op_mode first differs from the registered mode
    task automatic run_readout(input string tag);
        step();
        check($sformatf("%s done_cleared", tag), {31'd0, output_done}, 32'd0);
        step();
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s pix k=%0d", tag, k), {8'd0, data_out}, {8'd0, exp_pix[k]});
            check($sformatf("%s jump k=%0d", tag, k), {31'd0, jump_out}, {31'd0, exp_jump[k]});
            check($sformatf("%s done k=%0d", tag, k), {31'd0, output_done}, (k == N - 1) ? 32'd1 : 32'd0);
            step();
        end
        check($sformatf("%s hold_pix", tag), {8'd0, data_out}, {8'd0, exp_pix[N-1]});
        check($sformatf("%s hold_done", tag), {31'd0, output_done}, 32'd1);
    endtask

    task automatic store_pixels(input int n, input bit rnd, input int base);
        logic [DATA_W-1:0] v;
        op_mode = 3'b110;
        step();
        op_mode = MODE_STORE;
        step();
        for (int i = 0; i < n; i++) begin
            v = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
            data_in = v;
            model_mem[i % N] = v;
            step();
        end
        check("store_quiet", {6'd0, data_out, jump_out, output_done}, 32'd0);
    endtask

    initial begin
        tbl[0] = {3'b010, 64'h0123456789ABCDEF, 16'h8888};
        tbl[1] = {3'b001, 64'h37BF26AE159D048C, 16'h8888};
        tbl[2] = {3'b011, 64'hC840D951EA62FB73, 16'h8888};
        tbl[3] = {3'b100, 64'hCDEF89AB45670123, 16'h8888};
        tbl[4] = {3'b101, 64'h32107654BA98FEDC, 16'h8888};
        tbl[5] = {3'b110, 64'hFEDCBA9876543210, 16'h8888};
        tbl[6] = {3'b111, 64'hFEDCBA9876543210, 16'h8888};

        rst     = 1'b1;
        op_mode = MODE_ROT180;
        data_in = '0;
        step();
        step();
        check("reset data_out", {8'd0, data_out}, 32'd0);
        check("reset jump_out", {31'd0, jump_out}, 32'd0);
        check("reset output_done", {31'd0, output_done}, 32'd0);
        rst = 1'b0;

        store_pixels(N, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            op_mode = tbl[i].mode;
            load_tbl(i);
            run_readout($sformatf("tbl%0d", i));
        end

        op_mode = MODE_ROT180;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check("midrst data_out", {8'd0, data_out}, 32'd0);
        check("midrst jump_out", {31'd0, jump_out}, 32'd0);
        check("midrst output_done", {31'd0, output_done}, 32'd0);
        rst = 1'b0;
        load_tbl(0);
        run_readout("after_rst");

        op_mode = MODE_ROT180;
        for (int i = 0; i < 6; i++) step();
        op_mode = MODE_MIRH;
        load_tbl(3);
        run_readout("switch");

        store_pixels(N + 1, 1'b0, 100);
        op_mode = 3'b110;
        load_model(3'b110);
        check("wrap addr0", {8'd0, exp_pix[0]}, 32'd116);
        run_readout("wrap");

        for (int r = 0; r < 6; r++) begin
            logic [2:0] m;
            store_pixels(N + ((r == 2) ? 3 : 0), 1'b1, 0);
            m = 3'($urandom_range(1, 7));
            op_mode = m;
            load_model(m);
            run_readout($sformatf("rnd%0d m=%0d", r, m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
